intpol2_iq_out_fifo: RTL and testbench
======================================

Name: intpol2_iq_out_fifo

Overview:
Synchronous dual-lane (I/Q) output FIFO that sits directly downstream of the intpol2_D4 IQ interpolator core. It captures the core's I_interp/Q_interp pairs on its write enable and drives the core's Afull_i back-pressure input. It presents the stored pairs to the next consumer (DAC formatter / DMA) over a valid/ready stream. Both lanes share one pointer set, so an I sample and its Q sample never separate.

Parameters:
DATA_WIDTH, 32, width of each I and Q sample
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries per lane
AFULL_MARGIN, 4, Afull_o asserts when count >= DEPTH - AFULL_MARGIN; legal range 1..DEPTH-1

Ports:
clk  input  1  clock, all logic on posedge
rstn  input  1  synchronous, active-high reset (asserted = 1), sampled on posedge clk
clear  input  1  synchronous flush, same effect as reset
wr_en  input  1  push request, driven by the core's Write_Enable_fifo
I_in  input  DATA_WIDTH  I sample to push (signed)
Q_in  input  DATA_WIDTH  Q sample to push (signed)
Afull_o  output  1  almost-full flag, drives the core's Afull_i
Full_o  output  1  count == DEPTH
m_valid  output  1  head entry available (count != 0)
m_ready  input  1  consumer accepts head entry
m_I  output  DATA_WIDTH  head I sample
m_Q  output  DATA_WIDTH  head Q sample
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
ovf  output  1  sticky overflow flag
peak_count  output  ADDR_WIDTH+1  maximum occupancy since reset or clear (see Optional Feature)

Behaviour:
- State: wr_ptr and rd_ptr (each ADDR_WIDTH bits, wrap modulo DEPTH), count register, ovf register, and two DATA_WIDTH x DEPTH storage arrays.
- Reset (rstn=1 at posedge) and clear act identically:
  - wr_ptr=0, rd_ptr=0, count=0, ovf=0, peak_count=0.
  - Storage contents are not reset.
  - Reset has priority over clear; clear has priority over wr_en and m_ready in the same cycle, so any push or pop in that cycle is discarded.
- pop = m_valid & m_ready.
  - On pop: rd_ptr increments (wraps DEPTH-1 -> 0).
- push = wr_en & (!Full_o | pop).
  - On push: I_in/Q_in are written at wr_ptr, then wr_ptr increments.
  - A write while full is accepted only if a pop occurs in the same cycle.
- Overflow: wr_en & Full_o & !pop drops the word and sets ovf=1. ovf stays set until reset or clear.
- No underflow path exists: pops only happen with m_valid=1, and m_ready with m_valid=0 is ignored.
- count update per cycle:
  - +1 on push only
  - -1 on pop only
  - unchanged on push+pop, or on neither
- Flags are combinational from the registered count:
  - m_valid = (count != 0)
  - Full_o = (count == DEPTH)
  - Afull_o = (count >= DEPTH - AFULL_MARGIN)
- Output data: m_I/m_Q = storage[rd_ptr], show-ahead (first-word fall-through).
  - Contents are don't-care while m_valid=0.
  - m_I/m_Q remain stable while m_valid=1 and m_ready=0.
- Latency:
  - Push at edge k -> m_valid=1 and data visible from edge k (one-cycle write-to-read latency).
  - Pop at edge k -> next entry presented from edge k.
- Afull_o is asserted AFULL_MARGIN entries before full, so the core can absorb its in-flight writes after it sees Afull_i without overflow.
- No combinational path from wr_en or m_ready to any output.

Optional Feature:
Macro INTPOL2_OFIFO_PEAK_EN.
- Defined: peak_count is a register, updated every cycle to max(peak_count, next count) and cleared by reset or clear. It gives a high-water mark for sizing DEPTH and AFULL_MARGIN.
- Undefined: the port remains but is tied to 0, and no register is synthesized.

Test Plan:
1. Reset: rstn=1 for 2 cycles with wr_en=1 -> then count=0, m_valid=0, Full_o=0, Afull_o=0, ovf=0, peak_count=0.
2. Almost-full: defaults, m_ready=0, push 12 pairs (I=n, Q=-n) -> Afull_o=0 after 11 pushes and 1 after the 12th (count=12); Full_o=0.
3. Overflow: push 16 pairs, then one more with I=0xDEAD, m_ready=0 -> Full_o=1, count=16, ovf=1; drain with m_ready=1 -> exactly 16 pairs in order (I=0..15), 0xDEAD never appears, ovf remains 1.
4. Full push+pop: count=16, wr_en=1 with I=100, m_ready=1 in the same cycle -> count stays 16, ovf=0, old head popped, 100 emerges as the 16th subsequent output.
5. Flush priority: count=5, clear=1 with wr_en=1 and m_ready=1 -> next cycle count=0, m_valid=0, ovf=0; the pushed word never appears.
6. Peak (macro defined): push 9, drain all, push 3 -> peak_count=9, count=3; with the macro undefined, peak_count=0 throughout.

Source files
------------

// File: rtl/intpol2_iq_out_fifo_if.sv
// Stream bundle between the interpolator core, the I/Q output FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport is the surrounding environment's view.
interface intpol2_iq_out_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] I_in;
  logic signed [DATA_WIDTH-1:0] Q_in;
  logic                         Afull_o;
  logic                         Full_o;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_I;
  logic signed [DATA_WIDTH-1:0] m_Q;

  modport slave (
    input  wr_en, I_in, Q_in, m_ready,
    output Afull_o, Full_o, m_valid, m_I, m_Q
  );

  modport master (
    output wr_en, I_in, Q_in, m_ready,
    input  Afull_o, Full_o, m_valid, m_I, m_Q
  );
endinterface

// File: rtl/intpol2_iq_out_fifo.sv
// Dual-lane (I/Q) show-ahead output FIFO with shared pointers, almost-full back-pressure and sticky overflow.
// Optional high-water mark register enabled by defining INTPOL2_OFIFO_PEAK_EN.
module intpol2_iq_out_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  intpol2_iq_out_fifo_if.slave  fifo,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic [ADDR_WIDTH:0]   peak_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  ovf_reg, ovf_next;
  logic                  full, valid, push, pop, flush;
  logic [DATA_WIDTH-1:0] lane_in  [2];
  logic [DATA_WIDTH-1:0] lane_out [2];

  assign flush = rstn | clear;
  assign valid = (count_reg != '0);
  assign full  = (count_reg == DEPTH_LVL);
  assign pop   = valid & fifo.m_ready & ~flush;
  assign push  = fifo.wr_en & (~full | pop) & ~flush;

  assign lane_in[0] = fifo.I_in;
  assign lane_in[1] = fifo.Q_in;

  // Both lanes share the pointer set so an I sample never separates from its Q sample.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr_reg] <= lane_in[gi];
    end
    assign lane_out[gi] = mem[rd_ptr_reg];
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
      ovf_next    = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if (fifo.wr_en & full & ~pop) ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

`ifdef INTPOL2_OFIFO_PEAK_EN
  logic [ADDR_WIDTH:0] peak_reg, peak_next;

  always_comb begin
    peak_next = peak_reg;
    if (clear)
      peak_next = '0;
    else if (count_next > peak_reg)
      peak_next = count_next;
  end

  always_ff @(posedge clk) begin
    if (rstn) peak_reg <= '0;
    else      peak_reg <= peak_next;
  end

  assign peak_count = peak_reg;
`else
  assign peak_count = '0;
`endif

  assign fifo.m_valid = valid;
  assign fifo.Full_o  = full;
  assign fifo.Afull_o = (count_reg >= AFULL_LVL);
  assign fifo.m_I     = lane_out[0];
  assign fifo.m_Q     = lane_out[1];
  assign count        = count_reg;
  assign ovf          = ovf_reg;
endmodule

// File: tb/tb_intpol2_iq_out_fifo.sv
// Directed bench for intpol2_iq_out_fifo: a table of per-cycle vectors plus hand-written corner sequences.
module tb_intpol2_iq_out_fifo;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clear;
  logic [AW:0]   count;
  logic          ovf;
  logic [AW:0]   peak_count;
  int            tests = 0;
  int            fails = 0;

  intpol2_iq_out_fifo_if #(.DATA_WIDTH(DW)) bus ();

  intpol2_iq_out_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_MARGIN(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .fifo       (bus.slave),
    .count      (count),
    .ovf        (ovf),
    .peak_count (peak_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic        m_ready;
    logic        clr;
    logic [31:0] i_val;
    logic [4:0]  exp_count;
    logic        exp_valid;
    logic        exp_full;
    logic        exp_afull;
    logic        exp_ovf;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] iv);
    bus.wr_en   = w;
    bus.m_ready = r;
    bus.I_in    = iv;
    bus.Q_in    = -iv;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic push_n(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 32'(base + k));
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
  endtask

  task automatic pop_expect(input string name, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, 32'd0);
      #1;
      check({name, " valid"}, 32'(bus.m_valid), 32'd1);
      check({name, " I"}, bus.m_I, 32'(first + k));
      check({name, " Q"}, bus.m_Q, -32'(first + k));
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [4:0] exp_peak;

    // Test 1: reset with wr_en held high
    clear = 1'b0;
    rstn  = 1'b1;
    drive(1'b1, 1'b0, 32'h1234);
    tick();
    tick();
    rstn = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    #1;
    check("rst count", 32'(count), 32'd0);
    check("rst valid", 32'(bus.m_valid), 32'd0);
    check("rst full", 32'(bus.Full_o), 32'd0);
    check("rst afull", 32'(bus.Afull_o), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst peak", 32'(peak_count), 32'd0);

    // Per-cycle vectors: wr, rdy, clr, I, count, valid, full, afull, ovf, head
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd10, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'd11, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd10};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd12, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd11};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'd0,  5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd12};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'd13, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd13};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 32'd14, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].wr_en, vecs[v].m_ready, vecs[v].i_val);
      clear = vecs[v].clr;
      tick();
      check($sformatf("vec%0d count", v), 32'(count), 32'(vecs[v].exp_count));
      check($sformatf("vec%0d valid", v), 32'(bus.m_valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d full", v), 32'(bus.Full_o), 32'(vecs[v].exp_full));
      check($sformatf("vec%0d afull", v), 32'(bus.Afull_o), 32'(vecs[v].exp_afull));
      check($sformatf("vec%0d ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d head I", v), bus.m_I, vecs[v].exp_head);
        check($sformatf("vec%0d head Q", v), bus.m_Q, -vecs[v].exp_head);
      end
    end
    clear = 1'b0;

    // Test 2: almost-full threshold at count 12
    do_clear();
    push_n(0, 11);
    check("afull@11 flag", 32'(bus.Afull_o), 32'd0);
    check("afull@11 count", 32'(count), 32'd11);
    push_n(11, 1);
    check("afull@12 flag", 32'(bus.Afull_o), 32'd1);
    check("afull@12 count", 32'(count), 32'd12);
    check("afull@12 full", 32'(bus.Full_o), 32'd0);

    // Test 3: overflow drops the word, drain returns 0..15
    push_n(12, 4);
    check("full@16 flag", 32'(bus.Full_o), 32'd1);
    check("full@16 ovf", 32'(ovf), 32'd0);
    push_n(32'hDEAD, 1);
    check("ovf full", 32'(bus.Full_o), 32'd1);
    check("ovf count", 32'(count), 32'd16);
    check("ovf flag", 32'(ovf), 32'd1);
    pop_expect("ovf drain", 0, 16);
    check("ovf drained valid", 32'(bus.m_valid), 32'd0);
    check("ovf sticky", 32'(ovf), 32'd1);

    // Test 4: push and pop together while full
    do_clear();
    push_n(200, 16);
    drive(1'b1, 1'b1, 32'd100);
    #1;
    check("fullpp old head", bus.m_I, 32'd200);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check("fullpp count", 32'(count), 32'd16);
    check("fullpp ovf", 32'(ovf), 32'd0);
    pop_expect("fullpp drain", 201, 15);
    pop_expect("fullpp last", 100, 1);
    check("fullpp empty", 32'(count), 32'd0);

    // Test 5: clear beats simultaneous push and pop, and clears ovf
    do_clear();
    push_n(300, 16);
    push_n(32'hBEEF, 1);
    check("flush pre ovf", 32'(ovf), 32'd1);
    pop_expect("flush predrain", 300, 11);
    check("flush pre count", 32'(count), 32'd5);
    drive(1'b1, 1'b1, 32'h777);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b0, 1'b0, 32'd0);
    check("flush count", 32'(count), 32'd0);
    check("flush valid", 32'(bus.m_valid), 32'd0);
    check("flush ovf", 32'(ovf), 32'd0);
    push_n(55, 1);
    check("flush after count", 32'(count), 32'd1);
    check("flush after head", bus.m_I, 32'd55);

    // Test 6: high-water mark
    do_clear();
    push_n(0, 9);
    pop_expect("peak drain", 0, 9);
    push_n(20, 3);
`ifdef INTPOL2_OFIFO_PEAK_EN
    exp_peak = 5'd9;
`else
    exp_peak = 5'd0;
`endif
    check("peak value", 32'(peak_count), 32'(exp_peak));
    check("peak count", 32'(count), 32'd3);
    do_clear();
    check("peak cleared", 32'(peak_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
